// File: rtl/rsa_pkg.sv
// Shared constants, FSM encoding and width helper for the RSA bit scanner.
package rsa_pkg;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r = 0;
        int unsigned x = 1;
        while (x < v) begin
            x = x << 1;
            r++;
        end
        return r;
    endfunction

    localparam logic RSA_SCAN_MSB = 1'b0;
    localparam logic RSA_SCAN_LSB = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } rsa_state_e;

endpackage

// File: rtl/rsa_chunk_prienc.sv
// Combinational priority encoder over one chunk: dir=0 highest set bit, dir=1 lowest.
module rsa_chunk_prienc
    import rsa_pkg::*;
#(
    parameter  int unsigned CHUNK_W = 32,
    localparam int unsigned POS_W   = clog2(CHUNK_W)
) (
    input  logic [CHUNK_W-1:0] chunk,
    input  logic               dir,
    output logic [POS_W-1:0]   pos,
    output logic               nz
);

    // Later hits overwrite earlier ones, so iteration order sets the priority.
    always_comb begin
        pos = '0;
        nz  = |chunk;
        if (dir == RSA_SCAN_MSB) begin
            for (int unsigned i = 0; i < CHUNK_W; i++) begin
                if (chunk[i]) pos = POS_W'(i);
            end
        end else begin
            for (int unsigned i = CHUNK_W; i > 0; i--) begin
                if (chunk[i-1]) pos = POS_W'(i - 1);
            end
        end
    end

endmodule

// File: rtl/rsa_bitscan.sv
// Multi-cycle bit-length / trailing-zero scanner, one CHUNK_W slice per cycle.
module rsa_bitscan
    import rsa_pkg::*;
#(
    parameter  int unsigned DATA_W  = 1024,
    parameter  int unsigned CHUNK_W = 32,
    localparam int unsigned NCHUNK  = DATA_W / CHUNK_W,
    localparam int unsigned OUT_W   = clog2(DATA_W + 1)
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iStart,
    input  logic              iMode,
    input  logic [DATA_W-1:0] iD,
    output logic              oBusy,
    output logic              oDone,
    output logic [OUT_W-1:0]  oNumBit,
    output logic              oZero
);

    localparam int unsigned CW_LOG = clog2(CHUNK_W);
    localparam int unsigned IDX_W  = (NCHUNK > 1) ? clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCHUNK - 1);

    rsa_state_e         state_q, state_d;
    logic [DATA_W-1:0]  data_q,  data_d;
    logic               mode_q,  mode_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic               done_q,  done_d;
    logic [OUT_W-1:0]   numbit_q, numbit_d;
    logic               zero_q,  zero_d;

    logic [CHUNK_W-1:0] chunk;
    logic [CW_LOG-1:0]  pos;
    logic               nz;
    logic               last;
    logic [OUT_W-1:0]   base;

    assign chunk = data_q[idx_q*CHUNK_W +: CHUNK_W];
    assign last  = (mode_q == RSA_SCAN_LSB) ? (idx_q == IDX_LAST) : (idx_q == '0);
    assign base  = OUT_W'(idx_q) << CW_LOG;

    rsa_chunk_prienc #(.CHUNK_W(CHUNK_W)) u_prienc (
        .chunk (chunk),
        .dir   (mode_q),
        .pos   (pos),
        .nz    (nz)
    );

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        mode_d   = mode_q;
        idx_d    = idx_q;
        done_d   = 1'b0;
        numbit_d = numbit_q;
        zero_d   = zero_q;
        unique case (state_q)
            ST_IDLE: begin
                if (iStart) begin
                    state_d = ST_SCAN;
                    data_d  = iD;
                    mode_d  = iMode;
                    idx_d   = (iMode == RSA_SCAN_LSB) ? '0 : IDX_LAST;
                end
            end
            ST_SCAN: begin
                if (nz || last) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    zero_d  = ~nz;
                    if (nz) begin
                        numbit_d = (mode_q == RSA_SCAN_LSB) ? base + OUT_W'(pos)
                                                            : base + OUT_W'(pos) + OUT_W'(1);
                    end else begin
                        numbit_d = (mode_q == RSA_SCAN_LSB) ? OUT_W'(DATA_W) : '0;
                    end
                end else begin
                    idx_d = (mode_q == RSA_SCAN_LSB) ? idx_q + IDX_W'(1) : idx_q - IDX_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q  <= ST_IDLE;
            data_q   <= '0;
            mode_q   <= 1'b0;
            idx_q    <= '0;
            done_q   <= 1'b0;
            numbit_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            mode_q   <= mode_d;
            idx_q    <= idx_d;
            done_q   <= done_d;
            numbit_q <= numbit_d;
            zero_q   <= zero_d;
        end
    end

    assign oBusy   = (state_q == ST_SCAN);
    assign oDone   = done_q;
    assign oNumBit = numbit_q;
    assign oZero   = zero_q;

endmodule

// File: doc/rsa_bitscan.md
Name: rsa_bitscan

Overview:
- Parametrised multi-cycle bit scanner for the RSA datapath.
- Mode 0 returns the bit length of an operand, i.e. highest set bit index + 1.
- Mode 1 returns the trailing-zero count, i.e. lowest set bit index; the binary-GCD and modular-inverse stages need this.
- Captures the operand at start and scans one CHUNK_W slice per cycle, ending at the first non-zero chunk.
- Sits between the key/exponent registers and the exponentiation and inverse controllers.

Parameters:
- DATA_W, 1024, operand width; must be a multiple of CHUNK_W.
- CHUNK_W, 32, bits examined per cycle; power of two, at least 2.
- NCHUNK, DATA_W/CHUNK_W, derived, not overridable.
- OUT_W, clog2(DATA_W+1), derived result width (11 at defaults).

Ports:
- iClk, in, 1, clock; all state updates on the rising edge.
- iRst, in, 1, reset; synchronous, active-high.
- iStart, in, 1, start request; accepted only when oBusy=0.
- iMode, in, 1, scan mode: 0 = bit length (MSB-first), 1 = trailing zeros (LSB-first); sampled with iStart.
- iD, in, DATA_W, operand; sampled with iStart.
- oBusy, out, 1, scan in progress.
- oDone, out, 1, one-cycle pulse when the result is valid.
- oNumBit, out, OUT_W, result; held until the next accepted start.
- oZero, out, 1, operand was all-zero; held with oNumBit.

Behaviour:
- Reset (iRst=1 at an edge): oBusy=0, oDone=0, oNumBit=0, oZero=0, scan index=0, data register=0. This applies mid-scan: the scan is aborted and no oDone is produced.
- Accept: iStart=1 and oBusy=0 at edge E.
  - iD goes into an internal register and iMode into the mode register.
  - Index is set to NCHUNK-1 for mode 0, or 0 for mode 1.
  - oBusy=1; oNumBit and oZero are left unchanged.
- Later changes to iD have no effect on an accepted scan. iStart while oBusy=1 is ignored.
- Scan step, every cycle with oBusy=1:
  - Combinationally examine chunk[idx] = data[idx*CHUNK_W +: CHUNK_W] in the priority encoder.
  - Mode 0 picks the highest set position p; mode 1 picks the lowest set position p.
- Stop condition: chunk non-zero, or last chunk reached (idx=0 in mode 0, idx=NCHUNK-1 in mode 1). On the next edge:
  - oBusy goes to 0 and oDone to 1.
  - Chunk non-zero, mode 0: oNumBit = idx*CHUNK_W + p + 1, oZero=0.
  - Chunk non-zero, mode 1: oNumBit = idx*CHUNK_W + p, oZero=0.
  - Last chunk also zero: oZero=1; oNumBit=0 in mode 0, oNumBit=DATA_W in mode 1.
- Otherwise the index steps down by 1 (mode 0) or up by 1 (mode 1). The index never wraps.
- Latency: with the first non-zero chunk at scan step s (0-based), oDone is high in cycle E+s+1. The maximum is NCHUNK cycles, including the zero-operand case.
- oDone is high for exactly one cycle.
- oBusy=0 during the oDone cycle, so an iStart in that cycle is accepted (back-to-back operation).
- Arithmetic: idx*CHUNK_W is a shift (CHUNK_W is a power of two). The sum is computed at OUT_W width, and DATA_W fits OUT_W by construction.
- FSM states:
  - IDLE: go to SCAN on accept.
  - SCAN: go to IDLE on the stop condition, or on reset.
  - oDone is a registered pulse, not a state.

Decomposition:
- Package rsa_pkg:
  - clog2 function.
  - Mode constants RSA_SCAN_MSB=1'b0 and RSA_SCAN_LSB=1'b1.
  - FSM state encodings.
- Sub-module rsa_chunk_prienc: combinational, parameter CHUNK_W, inputs chunk and dir, outputs pos[clog2(CHUNK_W)-1:0] and nz. dir=0 selects highest set bit; dir=1 selects lowest set bit.
- The top level holds the data register, index counter, FSM and result registers.

Test Plan (DATA_W=1024, CHUNK_W=32):
- iD=1, mode 0 -> oNumBit=1, oZero=0; oDone at E+32; oBusy high for exactly 32 cycles.
- iD=2^1023, mode 0 -> oNumBit=1024 with oDone at E+1. Same iD in mode 1 -> oNumBit=1023 with oDone at E+32.
- iD with bits 37 and 500 set:
  - Mode 1 -> oNumBit=37, oDone at E+2.
  - Mode 0 -> oNumBit=501, oDone at E+17.
- iD=0:
  - Mode 0 -> oNumBit=0, oZero=1, oDone at E+32.
  - Mode 1 -> oNumBit=1024, oZero=1.
- Robustness, run as four separate checks:
  - Change iD one cycle after start -> result matches the captured value.
  - iStart pulses while busy are ignored, with no extra oDone.
  - iRst mid-scan -> oBusy=0 on the next edge, no oDone, outputs 0.
  - iStart in the oDone cycle is accepted and the second result is correct.
